// File: rtl/bcd_defs.sv
// Shared constants and helpers for the double-dabble binary-to-BCD converter.
package bcd_defs;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;
   localparam logic [3:0] BCD_NINE       = 4'h9;

   // 10^d at 64-bit width, used at elaboration time for the range limit.
   function automatic logic [63:0] pow10(input int d);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < d; i++) p = p * 64'd10;
      return p;
   endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// Add-3 correction for one BCD nibble ahead of the next left shift.
module bcd_nibble_adj
   import bcd_defs::*;
(
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= BCD_ADJ_THRESH) ? (din + BCD_ADJ_ADD) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake
// and all-nines saturation when the input exceeds DIGITS decimal digits.
module bin2bcd_seq
   import bcd_defs::*;
#(
   parameter int N      = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [N-1:0]          bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int          BW      = 4 * DIGITS;
   localparam int          CW      = $clog2(N + 1);
   localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

   logic          state, state_nxt;
   logic [N-1:0]  shreg;
   logic [BW-1:0] scratch;
   logic [BW-1:0] adj;
   logic [BW-1:0] shifted;
   logic [CW-1:0] count;
   logic          ovf_l;
   logic          load_en;
   logic          last_shift;

   function automatic logic [BW-1:0] sat_result(input logic ovf, input logic [BW-1:0] val);
      return ovf ? {DIGITS{BCD_NINE}} : val;
   endfunction

   for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      bcd_nibble_adj u_adj (
         .din  (scratch[4*k +: 4]),
         .dout (adj[4*k +: 4])
      );
   end

   // Carry out of the top nibble is intentionally dropped by the shift.
   assign shifted = (adj << 1) | BW'(shreg[N-1]);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start)      state_nxt = ST_SHIFT;
         ST_SHIFT: if (last_shift) state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == ST_SHIFT);
      load_en    = (state == ST_IDLE) && start;
      last_shift = (state == ST_SHIFT) && (count == CW'(1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         scratch  <= '0;
         count    <= '0;
         ovf_l    <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load_en) begin
            shreg   <= bin;
            scratch <= '0;
            count   <= CW'(N);
            ovf_l   <= (64'(bin) > MAX_VAL);
         end else if (busy) begin
            scratch <= shifted;
            shreg   <= shreg << 1;
            count   <= count - CW'(1);
            if (last_shift) begin
               bcd      <= sat_result(ovf_l, shifted);
               overflow <= ovf_l;
               done     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (default and N=8/DIGITS=3 builds).
module tb_bin2bcd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [13:0] bin;
   logic        busy, done, overflow;
   logic [15:0] bcd;

   logic        start2;
   logic [7:0]  bin2;
   logic        busy2, done2, overflow2;
   logic [11:0] bcd2;

   int checks = 0;
   int errors = 0;

   bin2bcd_seq dut (
      .clk(clk), .rst(rst), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
   );

   bin2bcd_seq #(.N(8), .DIGITS(3)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .bin(bin2),
      .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle start pulse, then wait (bounded) for done. lat = edges after
   // the accepting edge until done (-1 on timeout); bsy = busy-high samples.
   task automatic run_conv(input logic [13:0] v, output int lat, output int bsy);
      bin   = v;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bsy = busy ? 1 : 0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done) begin lat = i; break; end
         if (busy) bsy++;
      end
   endtask

   task automatic test_reset();
      int ndone;
      rst = 1'b1; start = 1'b0; start2 = 1'b0; bin = '0; bin2 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if ({busy, done, overflow, bcd} !== 19'h0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b ovf=%b bcd=%h, required all 0", busy, done, overflow, bcd);
      end
      ndone = 0;
      repeat (20) begin @(posedge clk); #1; if (done || busy) ndone++; end
      checks++;
      if (ndone !== 0) begin
         errors++;
         $display("FAIL reset_idle: %0d cycles with done/busy, required 0", ndone);
      end
   endtask

   task automatic test_basic();
      int lat, bsy;
      run_conv(14'd1234, lat, bsy);
      checks++;
      if (lat !== 14) begin errors++; $display("FAIL basic_latency: got %0d, required 14", lat); end
      checks++;
      if (bsy !== 14) begin errors++; $display("FAIL basic_busy: got %0d cycles, required 14", bsy); end
      checks++;
      if (bcd !== 16'h1234 || overflow !== 1'b0) begin
         errors++; $display("FAIL basic_value: bcd=%h ovf=%b, required 1234/0", bcd, overflow);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || bcd !== 16'h1234) begin
         errors++; $display("FAIL basic_hold: done=%b bcd=%h, required 0/1234", done, bcd);
      end
   endtask

   task automatic test_values();
      logic [13:0] vin [6]  = '{14'd0, 14'd9999, 14'd7, 14'd10000, 14'd16383, 14'd42};
      logic [15:0] vexp [6] = '{16'h0000, 16'h9999, 16'h0007, 16'h9999, 16'h9999, 16'h0042};
      logic        oexp [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      int lat, bsy;
      for (int i = 0; i < 6; i++) begin
         run_conv(vin[i], lat, bsy);
         checks++;
         if (lat !== 14 || bcd !== vexp[i] || overflow !== oexp[i]) begin
            errors++;
            $display("FAIL value_%0d: lat=%0d bcd=%h ovf=%b, required 14/%h/%b",
                     vin[i], lat, bcd, overflow, vexp[i], oexp[i]);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int ndone, first;
      ndone = 0; first = -1;
      bin = 14'd55; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 5) begin bin = 14'd66; start = 1'b1; end
         if (i == 6) start = 1'b0;
         @(posedge clk); #1;
         if (done) begin ndone++; if (first < 0) first = i; end
      end
      checks++;
      if (ndone !== 1 || first !== 14) begin
         errors++; $display("FAIL busy_ignore: %0d done pulses first at %0d, required 1 at 14", ndone, first);
      end
      checks++;
      if (bcd !== 16'h0055) begin errors++; $display("FAIL busy_ignore_value: bcd=%h, required 0055", bcd); end
   endtask

   // The done cycle is already IDLE, so a held start is taken at the next edge:
   // done pulses are N+1 = 15 edges apart with only that one non-busy cycle.
   task automatic test_back_to_back();
      int ndone, last, gap_err, idle_cyc;
      ndone = 0; last = 0; gap_err = 0; idle_cyc = 0;
      bin = 14'd321; start = 1'b1;
      @(posedge clk); #1;
      for (int i = 1; i <= 46; i++) begin
         @(posedge clk); #1;
         if (!busy) idle_cyc++;
         if (done) begin
            if ((ndone == 0 && i != 14) || (ndone > 0 && i - last != 15)) gap_err++;
            ndone++; last = i;
         end
      end
      start = 1'b0;
      checks++;
      if (ndone !== 3 || gap_err !== 0) begin
         errors++; $display("FAIL back_to_back_timing: %0d pulses, %0d bad gaps, required 3/0", ndone, gap_err);
      end
      checks++;
      if (idle_cyc !== 3) begin
         errors++; $display("FAIL back_to_back_idle: %0d non-busy cycles, required 3", idle_cyc);
      end
      checks++;
      if (bcd !== 16'h0321 || overflow !== 1'b0) begin
         errors++; $display("FAIL back_to_back_value: bcd=%h ovf=%b, required 0321/0", bcd, overflow);
      end
      repeat (20) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int ndone, lat, bsy;
      bin = 14'd8765; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b bcd=%h ovf=%b, required 0/0/0000/0", busy, done, bcd, overflow);
      end
      ndone = 0;
      repeat (20) begin @(posedge clk); #1; if (done) ndone++; end
      checks++;
      if (ndone !== 0 || bcd !== 16'h0) begin
         errors++; $display("FAIL reset_mid_no_done: %0d pulses bcd=%h, required 0/0000", ndone, bcd);
      end
      run_conv(14'd8765, lat, bsy);
      checks++;
      if (lat !== 14 || bcd !== 16'h8765) begin
         errors++; $display("FAIL reset_mid_rerun: lat=%0d bcd=%h, required 14/8765", lat, bcd);
      end
   endtask

   task automatic test_param();
      int lat;
      bin2 = 8'd255; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk); #1;
         if (done2) begin lat = i; break; end
      end
      checks++;
      if (lat !== 8 || bcd2 !== 12'h255 || overflow2 !== 1'b0) begin
         errors++; $display("FAIL param_255: lat=%0d bcd=%h ovf=%b, required 8/255/0", lat, bcd2, overflow2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_values();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      test_param();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
